inst_fetch_stage: RTL and testbench
===================================

Name: inst_fetch_stage

Overview:
- IF pipeline stage, directly downstream of the pre-IF stage.
- Accepts a PC and any pre-IF exception once pre-IF has completed its address handshake.
- Waits for the instruction SRAM data_ok response and buffers the instruction when ID stalls.
- On a pipeline flush, discards responses for requests already in flight. Returns its PC to pre-IF for sequential PC generation.

Parameters:
PC_W, 32, PC and address width
INST_W, 32, instruction width
EXC_W, 8, exception-type vector width
ADEF_BIT, 1, bit index of ADEF in exception-type vector
NOP_INST, 32'h03400000, instruction forwarded when no fetch was issued

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
preif_valid_i  in  1  pre-IF has data for IF (address handshake done or exception)
preif_req_i  in  1  pre-IF issued an SRAM request for this PC
preif_pc_i  in  PC_W  PC of incoming fetch
preif_excp_en_i  in  1  pre-IF exception flag
preif_excp_type_i  in  EXC_W  pre-IF exception vector
allowin_o  out  1  IF can accept from pre-IF
inst_sram_data_ok_i  in  1  instruction response valid
inst_sram_rdata_i  in  INST_W  instruction response data
excep_flush_i  in  1  pipeline flush (exception/ertn/tlb refetch)
id_allowin_i  in  1  ID can accept
to_id_valid_o  out  1  IF output valid to ID
if_pc_o  out  PC_W  PC to ID
if_inst_o  out  INST_W  instruction to ID
if_excp_en_o  out  1  exception flag to ID
if_excp_type_o  out  EXC_W  exception vector to ID
order_we_o  out  1  IF holds a valid PC (pre-IF uses order_pc+4)
order_pc_o  out  PC_W  current IF PC

Behaviour:
- Registers: if_valid, pc, excp_en, excp_type, wait_rsp, buf_valid, buf_inst, cancel_cnt (2 bits, saturating at 3).
- Reset values: all registers 0. Outputs at reset: to_id_valid_o=0, allowin_o=1, order_we_o=0, all data outputs 0.
- ready_go = excp_en | buf_valid | (wait_rsp & data_ok & cancel_cnt==0).
- to_id_valid_o = if_valid & ready_go & ~excep_flush_i.
- allowin_o = ~if_valid | (ready_go & id_allowin_i) | excep_flush_i.
- Load: when allowin_o & preif_valid_i & ~excep_flush_i:
  - if_valid<=1; pc, excp_en and excp_type load from pre-IF.
  - wait_rsp<=preif_req_i.
  - buf_valid<=0.
- Drain: if ready_go & id_allowin_i & no load, then if_valid<=0.
- Zero latency: an instruction arriving with data_ok in the same cycle ID allows in is forwarded combinationally, with no buffer write.
- Accepted response: when data_ok & cancel_cnt==0 & wait_rsp:
  - wait_rsp<=0.
  - If ~id_allowin_i, then buf_inst<=rdata and buf_valid<=1.
- if_inst_o selection:
  - buf_valid: buf_inst.
  - ~wait_rsp & ~buf_valid (exception without fetch): NOP_INST.
  - otherwise: inst_sram_rdata_i.
- Cancel: when data_ok & cancel_cnt!=0, cancel_cnt decrements and the data is dropped. This takes priority over the accepted-response case.
- Flush: on excep_flush_i, if_valid<=0, wait_rsp<=0, buf_valid<=0.
  - If wait_rsp=1 and no data_ok arrives this cycle with cancel_cnt==0, cancel_cnt increments.
  - Flush with a same-cycle matching data_ok: the response is consumed and dropped; cancel_cnt is unchanged.
  - Flush with a same-cycle cancel data_ok: decrement and increment both apply (net 0).
- Pre-IF issues while cancel_cnt!=0: the new request loads normally. Its response is accepted only after cancel_cnt returns to 0; responses are in order.
- Unexpected data_ok (wait_rsp=0, cancel_cnt=0): data is ignored and state is unchanged.
- order_we_o = if_valid; order_pc_o = pc.
- Output exception fields pass through from registers.

Optional Feature:
- Macro: IF_ADEF_CHECK_EN.
- Defined: on load, if preif_pc_i[1:0]!=0 and preif_excp_en_i=0:
  - excp_en<=1 and excp_type[ADEF_BIT]<=1.
  - If preif_req_i=1, wait_rsp<=0 and cancel_cnt increments, so the issued response is discarded.
  - if_inst_o = NOP_INST.
- Undefined: no alignment check; pre-IF exception fields pass through unchanged.

Test Plan:
- Basic fetch: preif_valid=1, req=1, pc=0x1c000000; data_ok next cycle with 0x02800421, id_allowin=1 -> to_id_valid=1 that cycle, if_inst=0x02800421, allowin=1.
- ID stall: data_ok with 0x12345678 while id_allowin=0 -> buf_valid=1, allowin=0. Two cycles later id_allowin=1 -> inst 0x12345678 issued, allowin=1.
- Flush in flight: load pc 0x1c000010, wait_rsp=1, flush asserted -> cancel_cnt=1. Next request for pc 0x1c008000 loads. First data_ok is dropped; second data_ok 0xAABBCCDD is issued with pc 0x1c008000.
- Exception without fetch: preif_valid=1, req=0, excp_en=1, type=0x01 -> to_id_valid=1 the next cycle, inst 0x03400000, excp_type 0x01.
- Flush plus data_ok in the same cycle with wait_rsp=1 -> cancel_cnt stays 0, to_id_valid=0.
- IF_ADEF_CHECK_EN: pc=0x1c000002, req=1 -> excp_type[1]=1, inst 0x03400000, and the following data_ok is discarded.

Source files
------------

// File: rtl/inst_fetch_stage.sv
// IF pipeline stage: holds the fetched PC, waits for the instruction SRAM response,
// buffers it across ID stalls and discards in-flight responses after a flush.
// Optional misaligned-PC (ADEF) check enabled by defining IF_ADEF_CHECK_EN.
module inst_fetch_stage #(
    parameter int unsigned       PC_W     = 32,
    parameter int unsigned       INST_W   = 32,
    parameter int unsigned       EXC_W    = 8,
    parameter int unsigned       ADEF_BIT = 1,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(32'h03400000)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              preif_valid_i,
    input  logic              preif_req_i,
    input  logic [PC_W-1:0]   preif_pc_i,
    input  logic              preif_excp_en_i,
    input  logic [EXC_W-1:0]  preif_excp_type_i,
    output logic              allowin_o,
    input  logic              inst_sram_data_ok_i,
    input  logic [INST_W-1:0] inst_sram_rdata_i,
    input  logic              excep_flush_i,
    input  logic              id_allowin_i,
    output logic              to_id_valid_o,
    output logic [PC_W-1:0]   if_pc_o,
    output logic [INST_W-1:0] if_inst_o,
    output logic              if_excp_en_o,
    output logic [EXC_W-1:0]  if_excp_type_o,
    output logic              order_we_o,
    output logic [PC_W-1:0]   order_pc_o
);

    logic              if_valid_q, if_valid_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              excp_en_q, excp_en_d;
    logic [EXC_W-1:0]  excp_type_q, excp_type_d;
    logic              wait_rsp_q, wait_rsp_d;
    logic              buf_valid_q, buf_valid_d;
    logic [INST_W-1:0] buf_inst_q, buf_inst_d;
    logic [1:0]        cancel_cnt_q, cancel_cnt_d;

    logic ready_go, load, accept, cancel_hit, cnt_inc, cnt_dec;

    always_comb begin
        cancel_hit = inst_sram_data_ok_i && (cancel_cnt_q != 2'd0);
        accept     = inst_sram_data_ok_i && (cancel_cnt_q == 2'd0) && wait_rsp_q;
        ready_go   = excp_en_q || buf_valid_q || accept;
        to_id_valid_o = if_valid_q && ready_go && !excep_flush_i;
        allowin_o     = !if_valid_q || (ready_go && id_allowin_i) || excep_flush_i;
        load          = allowin_o && preif_valid_i && !excep_flush_i;

        if_valid_d   = if_valid_q;
        pc_d         = pc_q;
        excp_en_d    = excp_en_q;
        excp_type_d  = excp_type_q;
        wait_rsp_d   = wait_rsp_q;
        buf_valid_d  = buf_valid_q;
        buf_inst_d   = buf_inst_q;
        cnt_dec      = cancel_hit;
        // A flush orphans the outstanding request unless its response lands this cycle.
        cnt_inc      = excep_flush_i && wait_rsp_q &&
                       !(inst_sram_data_ok_i && (cancel_cnt_q == 2'd0));

        if (accept) begin
            wait_rsp_d = 1'b0;
            if (!id_allowin_i) begin
                buf_inst_d  = inst_sram_rdata_i;
                buf_valid_d = 1'b1;
            end
        end

        if (ready_go && id_allowin_i && !load) begin
            if_valid_d = 1'b0;
        end

        if (excep_flush_i) begin
            if_valid_d  = 1'b0;
            wait_rsp_d  = 1'b0;
            buf_valid_d = 1'b0;
        end

        if (load) begin
            if_valid_d  = 1'b1;
            pc_d        = preif_pc_i;
            excp_en_d   = preif_excp_en_i;
            excp_type_d = preif_excp_type_i;
            wait_rsp_d  = preif_req_i;
            buf_valid_d = 1'b0;
`ifdef IF_ADEF_CHECK_EN
            if ((preif_pc_i[1:0] != 2'b00) && !preif_excp_en_i) begin
                excp_en_d              = 1'b1;
                excp_type_d[ADEF_BIT]  = 1'b1;
                // The fetch already went out; drop its response instead of using it.
                if (preif_req_i) begin
                    wait_rsp_d = 1'b0;
                    cnt_inc    = 1'b1;
                end
            end
`endif
        end

        cancel_cnt_d = cancel_cnt_q;
        if (cnt_inc && !cnt_dec && (cancel_cnt_q != 2'd3)) begin
            cancel_cnt_d = cancel_cnt_q + 2'd1;
        end else if (cnt_dec && !cnt_inc) begin
            cancel_cnt_d = cancel_cnt_q - 2'd1;
        end

        if (buf_valid_q) begin
            if_inst_o = buf_inst_q;
        end else if (!wait_rsp_q) begin
            if_inst_o = NOP_INST;
        end else begin
            if_inst_o = inst_sram_rdata_i;
        end

        if_pc_o        = pc_q;
        if_excp_en_o   = excp_en_q;
        if_excp_type_o = excp_type_q;
        order_we_o     = if_valid_q;
        order_pc_o     = pc_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_valid_q   <= 1'b0;
            pc_q         <= '0;
            excp_en_q    <= 1'b0;
            excp_type_q  <= '0;
            wait_rsp_q   <= 1'b0;
            buf_valid_q  <= 1'b0;
            buf_inst_q   <= '0;
            cancel_cnt_q <= 2'd0;
        end else begin
            if_valid_q   <= if_valid_d;
            pc_q         <= pc_d;
            excp_en_q    <= excp_en_d;
            excp_type_q  <= excp_type_d;
            wait_rsp_q   <= wait_rsp_d;
            buf_valid_q  <= buf_valid_d;
            buf_inst_q   <= buf_inst_d;
            cancel_cnt_q <= cancel_cnt_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Scoreboard bench for inst_fetch_stage: directed fetches push expected ID transfers,
// a negedge monitor pops and compares every accepted to_id transfer.
module tb_inst_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        preif_valid_i, preif_req_i, preif_excp_en_i;
    logic [31:0] preif_pc_i;
    logic [7:0]  preif_excp_type_i;
    logic        allowin_o;
    logic        inst_sram_data_ok_i;
    logic [31:0] inst_sram_rdata_i;
    logic        excep_flush_i, id_allowin_i;
    logic        to_id_valid_o;
    logic [31:0] if_pc_o, if_inst_o, order_pc_o;
    logic        if_excp_en_o, order_we_o;
    logic [7:0]  if_excp_type_o;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        en;
        logic [7:0]  typ;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    inst_fetch_stage #(
        .PC_W(32), .INST_W(32), .EXC_W(8), .ADEF_BIT(1), .NOP_INST(32'h03400000)
    ) dut (
        .clk(clk), .rst(rst),
        .preif_valid_i(preif_valid_i), .preif_req_i(preif_req_i), .preif_pc_i(preif_pc_i),
        .preif_excp_en_i(preif_excp_en_i), .preif_excp_type_i(preif_excp_type_i),
        .allowin_o(allowin_o),
        .inst_sram_data_ok_i(inst_sram_data_ok_i), .inst_sram_rdata_i(inst_sram_rdata_i),
        .excep_flush_i(excep_flush_i), .id_allowin_i(id_allowin_i),
        .to_id_valid_o(to_id_valid_o), .if_pc_o(if_pc_o), .if_inst_o(if_inst_o),
        .if_excp_en_o(if_excp_en_o), .if_excp_type_o(if_excp_type_o),
        .order_we_o(order_we_o), .order_pc_o(order_pc_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] inst,
                        input logic en, input logic [7:0] typ);
        exp_t e;
        e.pc = pc; e.inst = inst; e.en = en; e.typ = typ;
        exp_q.push_back(e);
    endtask

    task automatic fetch(input logic [31:0] pc, input logic req);
        preif_valid_i = 1'b1; preif_req_i = req; preif_pc_i = pc;
        step();
        preif_valid_i = 1'b0; preif_req_i = 1'b0;
    endtask

    // Monitor: every accepted IF->ID transfer must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && to_id_valid_o && id_allowin_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_xfer: got pc %h inst %h expected no transfer",
                         if_pc_o, if_inst_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                if (if_pc_o !== e.pc || if_inst_o !== e.inst ||
                    if_excp_en_o !== e.en || if_excp_type_o !== e.typ) begin
                    errors++;
                    $display("FAIL xfer: got pc %h inst %h en %b type %h expected pc %h inst %h en %b type %h",
                             if_pc_o, if_inst_o, if_excp_en_o, if_excp_type_o,
                             e.pc, e.inst, e.en, e.typ);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        preif_valid_i = 0; preif_req_i = 0; preif_pc_i = '0;
        preif_excp_en_i = 0; preif_excp_type_i = '0;
        inst_sram_data_ok_i = 0; inst_sram_rdata_i = '0;
        excep_flush_i = 0; id_allowin_i = 1;

        @(negedge clk);
        chk("rst_to_id_valid", {31'd0, to_id_valid_o}, 32'd0);
        chk("rst_allowin", {31'd0, allowin_o}, 32'd1);
        chk("rst_order_we", {31'd0, order_we_o}, 32'd0);
        chk("rst_if_pc", if_pc_o, 32'd0);
        chk("rst_excp", {23'd0, if_excp_en_o, if_excp_type_o}, 32'd0);
        step();
        rst = 1'b0;
        step();

        // Basic fetch with zero-latency forwarding
        fetch(32'h1c000000, 1'b1);
        inst_sram_data_ok_i = 1; inst_sram_rdata_i = 32'h02800421;
        push(32'h1c000000, 32'h02800421, 1'b0, 8'h00);
        @(negedge clk);
        chk("basic_to_id_valid", {31'd0, to_id_valid_o}, 32'd1);
        chk("basic_allowin", {31'd0, allowin_o}, 32'd1);
        chk("basic_order_we", {31'd0, order_we_o}, 32'd1);
        chk("basic_order_pc", order_pc_o, 32'h1c000000);
        step();
        inst_sram_data_ok_i = 0;

        // ID stall: response buffered, released two cycles later
        id_allowin_i = 0;
        fetch(32'h1c000004, 1'b1);
        inst_sram_data_ok_i = 1; inst_sram_rdata_i = 32'h12345678;
        @(negedge clk);
        chk("stall_allowin_rsp", {31'd0, allowin_o}, 32'd0);
        step();
        inst_sram_data_ok_i = 0; inst_sram_rdata_i = 32'hffffffff;
        @(negedge clk);
        chk("stall_allowin_buf", {31'd0, allowin_o}, 32'd0);
        chk("stall_to_id_valid_buf", {31'd0, to_id_valid_o}, 32'd1);
        step();
        id_allowin_i = 1;
        push(32'h1c000004, 32'h12345678, 1'b0, 8'h00);
        @(negedge clk);
        chk("stall_release_allowin", {31'd0, allowin_o}, 32'd1);
        step();

        // Flush with a request in flight: first response dropped
        fetch(32'h1c000010, 1'b1);
        excep_flush_i = 1;
        @(negedge clk);
        chk("flush_to_id_valid", {31'd0, to_id_valid_o}, 32'd0);
        step();
        excep_flush_i = 0;
        fetch(32'h1c008000, 1'b1);
        inst_sram_data_ok_i = 1; inst_sram_rdata_i = 32'hdeadbeef;
        @(negedge clk);
        chk("cancel_drop_valid", {31'd0, to_id_valid_o}, 32'd0);
        step();
        inst_sram_rdata_i = 32'haabbccdd;
        push(32'h1c008000, 32'haabbccdd, 1'b0, 8'h00);
        step();
        inst_sram_data_ok_i = 0;

        // Exception without fetch
        preif_excp_en_i = 1; preif_excp_type_i = 8'h01;
        fetch(32'h1c00a000, 1'b0);
        preif_excp_en_i = 0; preif_excp_type_i = 8'h00;
        push(32'h1c00a000, 32'h03400000, 1'b1, 8'h01);
        @(negedge clk);
        chk("excp_to_id_valid", {31'd0, to_id_valid_o}, 32'd1);
        step();

        // Flush with same-cycle matching data_ok: nothing left to cancel
        fetch(32'h1c00c000, 1'b1);
        excep_flush_i = 1; inst_sram_data_ok_i = 1; inst_sram_rdata_i = 32'h11111111;
        @(negedge clk);
        chk("flush_ok_to_id_valid", {31'd0, to_id_valid_o}, 32'd0);
        step();
        excep_flush_i = 0; inst_sram_data_ok_i = 0;
        fetch(32'h1c00d000, 1'b1);
        inst_sram_data_ok_i = 1; inst_sram_rdata_i = 32'h22222222;
        push(32'h1c00d000, 32'h22222222, 1'b0, 8'h00);
        @(negedge clk);
        chk("flush_ok_next_valid", {31'd0, to_id_valid_o}, 32'd1);
        step();
        inst_sram_data_ok_i = 0;

        // Unexpected data_ok while idle is ignored
        inst_sram_data_ok_i = 1; inst_sram_rdata_i = 32'h33333333;
        @(negedge clk);
        chk("unexp_to_id_valid", {31'd0, to_id_valid_o}, 32'd0);
        chk("unexp_allowin", {31'd0, allowin_o}, 32'd1);
        step();
        inst_sram_data_ok_i = 0;

        // Flush coinciding with a cancelled response: count stays at 1
        fetch(32'h1c00e000, 1'b1);
        excep_flush_i = 1;
        step();
        excep_flush_i = 0;
        fetch(32'h1c00e004, 1'b1);
        excep_flush_i = 1; inst_sram_data_ok_i = 1; inst_sram_rdata_i = 32'h44440000;
        @(negedge clk);
        chk("net0_flush_valid", {31'd0, to_id_valid_o}, 32'd0);
        step();
        excep_flush_i = 0; inst_sram_data_ok_i = 0;
        fetch(32'h1c00e008, 1'b1);
        inst_sram_data_ok_i = 1; inst_sram_rdata_i = 32'h44444444;
        @(negedge clk);
        chk("net0_drop_valid", {31'd0, to_id_valid_o}, 32'd0);
        step();
        inst_sram_rdata_i = 32'h55555555;
        push(32'h1c00e008, 32'h55555555, 1'b0, 8'h00);
        @(negedge clk);
        chk("net0_accept_valid", {31'd0, to_id_valid_o}, 32'd1);
        step();
        inst_sram_data_ok_i = 0;

`ifdef IF_ADEF_CHECK_EN
        // Misaligned PC: ADEF raised, issued response discarded
        fetch(32'h1c000002, 1'b1);
        push(32'h1c000002, 32'h03400000, 1'b1, 8'h02);
        @(negedge clk);
        chk("adef_to_id_valid", {31'd0, to_id_valid_o}, 32'd1);
        step();
        inst_sram_data_ok_i = 1; inst_sram_rdata_i = 32'h66666666;
        @(negedge clk);
        chk("adef_drop_valid", {31'd0, to_id_valid_o}, 32'd0);
        step();
        inst_sram_data_ok_i = 0;
        fetch(32'h1c000008, 1'b1);
        inst_sram_data_ok_i = 1; inst_sram_rdata_i = 32'h77777777;
        push(32'h1c000008, 32'h77777777, 1'b0, 8'h00);
        step();
        inst_sram_data_ok_i = 0;
`endif

        step();
        step();
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
